sram_result_reader: RTL

Hardware reader for port B of a dp_sram_coregen result memory (P). After ShortestPath_4 asserts Done, this block sweeps the P memory from address 0 over port B, reads one 32-bit word per address, and presents each word with its address on a valid/ready stream toward a host or UART bridge. It replaces the bench's sequential read-and-check loop with synthesizable logic and pipelines reads around the 1-cycle SRAM read latency.

---
 rtl/sram_result_reader_pkg.sv | 15 +
 rtl/rr_skid_fifo.sv | 41 ++++
 rtl/sram_result_reader.sv | 115 +++++++++++
 3 files changed

// File: rtl/sram_result_reader_pkg.sv
// rtl/sram_result_reader_pkg.sv - shared widths and FSM encoding for the result-memory reader
package sram_result_reader_pkg;
    localparam int A_INIT_WIDTH = 11;
    localparam int D_INIT_WIDTH = 32;
    localparam int FIFO_DEPTH   = 2;
    localparam int ENTRY_WIDTH  = A_INIT_WIDTH + D_INIT_WIDTH;
    localparam logic [A_INIT_WIDTH:0] MAX_LEN = (A_INIT_WIDTH+1)'(1) << A_INIT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rr_state_t;
endpackage

// File: rtl/rr_skid_fifo.sv
// rtl/rr_skid_fifo.sv - two-entry {index, data} buffer absorbing the SRAM read latency
module rr_skid_fifo
    import sram_result_reader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [ENTRY_WIDTH-1:0] push_data,
    input  logic                   pop,
    output logic [ENTRY_WIDTH-1:0] pop_data,
    output logic                   full,
    output logic                   empty
);
    logic [ENTRY_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;

    assign pop_data = mem[rd_ptr];
    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/sram_result_reader.sv
// rtl/sram_result_reader.sv - sweeps result memory port B and streams {index, data} words
module sram_result_reader
    import sram_result_reader_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Start,
    input  logic [A_INIT_WIDTH:0]   Length,
    output logic [A_INIT_WIDTH-1:0] Addr_B,
    output logic                    En_B,
    output logic                    We_B,
    input  logic [D_INIT_WIDTH-1:0] In_B,
    output logic [D_INIT_WIDTH-1:0] Data_Out,
    output logic [A_INIT_WIDTH-1:0] Index_Out,
    output logic                    Valid,
    input  logic                    Ready,
    output logic                    Busy,
    output logic                    Done
);
    rr_state_t               state;
    logic [A_INIT_WIDTH:0]   len_q;
    logic [A_INIT_WIDTH:0]   issue_cnt;
    logic [A_INIT_WIDTH-1:0] last_addr;
    logic [A_INIT_WIDTH-1:0] tag;
    logic                    inflight;
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    issue;
    logic [1:0]              occ;
    logic [2:0]              credit_use;
    logic [A_INIT_WIDTH:0]   len_clamped;
    logic [ENTRY_WIDTH-1:0]  head;

    assign pop         = Valid && Ready;
    assign occ         = full ? 2'd2 : (empty ? 2'd0 : 2'd1);
    // A word popped this cycle frees its slot for a read issued this cycle.
    assign credit_use  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign issue       = (state == ST_READ) && (credit_use < 3'(FIFO_DEPTH));
    assign len_clamped = (Length > MAX_LEN) ? MAX_LEN : Length;

    assign En_B      = issue;
    assign Addr_B    = issue ? issue_cnt[A_INIT_WIDTH-1:0] : last_addr;
    assign We_B      = 1'b0;
    assign Valid     = !empty;
    assign Index_Out = head[ENTRY_WIDTH-1:D_INIT_WIDTH];
    assign Data_Out  = head[D_INIT_WIDTH-1:0];

    rr_skid_fifo u_fifo (
        .clk       (Clk),
        .rst_n     (Rst),
        .push      (inflight),
        .push_data ({tag, In_B}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            issue_cnt <= '0;
            last_addr <= '0;
            tag       <= '0;
            inflight  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag       <= issue_cnt[A_INIT_WIDTH-1:0];
                last_addr <= issue_cnt[A_INIT_WIDTH-1:0];
            end
            case (state)
                ST_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        len_q     <= len_clamped;
                        issue_cnt <= '0;
                        if (len_clamped == '0) begin
                            state <= ST_DONE;
                            Done  <= 1'b1;
                        end else begin
                            state <= ST_READ;
                            Busy  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_cnt + 1'b1 == len_q) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Finish as soon as the final word leaves the buffer.
                    if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
                        state <= ST_DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    Done  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
